// File: rtl/crc_frame_tx_pkg.sv
// ============================================================================
// crc_frame_tx_pkg : shared framer state encoding and CRC-8 constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package crc_frame_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2,
      ST_CRC     = 2'd3
   } state_e;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;
   // Must match the receive-side checker so both ends agree on the CRC.
   localparam logic [7:0] CRC_POLY    = 8'h07;
   localparam logic [7:0] CRC_INIT    = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/crc_frame_tx_if.sv
// ============================================================================
// crc_frame_tx_if : payload stream, serializer stream and CRC engine bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface crc_frame_tx_if;
   logic       valid;
   logic       ready;
   logic [7:0] data;
   logic       last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       crc_init;
   logic       crc_calc;
   logic [7:0] crc_data;
   logic [7:0] crc;

   modport slave (
      input  valid, data, last, tx_ready, crc,
      output ready, tx_valid, tx_data, crc_init, crc_calc, crc_data
   );

   modport master (
      output valid, data, last, tx_ready, crc,
      input  ready, tx_valid, tx_data, crc_init, crc_calc, crc_data
   );
endinterface

`default_nettype wire

// File: rtl/crc_frame_tx.sv
// ============================================================================
// crc_frame_tx : frames payload packets as SOF, payload, CRC-8 byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_frame_tx
   import crc_frame_tx_pkg::*;
#(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] SOF     = SOF_DEFAULT,
   parameter int         CNT_W   = 16
) (
   input  wire logic             i_clk,
   input  wire logic             i_arst_n,
   crc_frame_tx_if.slave         bus,
   output logic                  o_busy,
   output logic                  o_len_err,
   output logic [CNT_W-1:0]      o_frame_cnt
);

   localparam logic [8:0] LEN_LIMIT = 9'(MAX_LEN);

   state_e             state_q,     state_d;
   logic               tx_valid_q,  tx_valid_d;
   logic [7:0]         tx_data_q,   tx_data_d;
   logic               len_err_q,   len_err_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]         count_q,     count_d;

   logic               reg_free;
   logic               ready;
   logic               crc_init;
   logic               crc_calc;

   assign reg_free = !tx_valid_q || bus.tx_ready;

   always_comb begin
      state_d     = state_q;
      tx_valid_d  = tx_valid_q && !bus.tx_ready;
      tx_data_d   = tx_data_q;
      len_err_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      count_d     = count_q;
      ready       = 1'b0;
      crc_init    = 1'b0;
      crc_calc    = 1'b0;

      case (state_q)
         // The upstream byte only triggers the SOF here; it is consumed in PAYLOAD.
         ST_IDLE: begin
            if (bus.valid && reg_free) begin
               tx_data_d  = SOF;
               tx_valid_d = 1'b1;
               crc_init   = 1'b1;
               state_d    = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            ready = reg_free;
            if (bus.valid && reg_free) begin
               tx_data_d  = bus.data;
               tx_valid_d = 1'b1;
               crc_calc   = 1'b1;
               count_d    = count_q + 8'd1;
               if (bus.last) begin
                  state_d = ST_CRC;
               end else if (({1'b0, count_q} + 9'd1) == LEN_LIMIT) begin
                  len_err_d = 1'b1;
                  state_d   = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            ready = 1'b1;
            if (bus.valid && bus.last) begin
               state_d = ST_CRC;
            end
         end
         ST_CRC: begin
            if (reg_free) begin
               tx_data_d   = bus.crc;
               tx_valid_d  = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
               count_d     = 8'd0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= ST_IDLE;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         len_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         count_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         len_err_q   <= len_err_d;
         frame_cnt_q <= frame_cnt_d;
         count_q     <= count_d;
      end
   end

   assign bus.ready    = ready;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.crc_init = crc_init;
   assign bus.crc_calc = crc_calc;
   assign bus.crc_data = bus.data;

   assign o_busy      = (state_q != ST_IDLE);
   assign o_len_err   = len_err_q;
   assign o_frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire
